// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-control bundle between the datapath stages and hazard_flush_ctrl.
// The master side drives the hazard/memory status; the slave side returns the freeze/flush controls.
interface hazard_flush_ctrl_if #(
  parameter int unsigned REG_W = 4
);
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_use_rn;
  logic             id_two_src;
  logic [REG_W-1:0] ex_dest;
  logic             ex_wb_en;
  logic             ex_mem_r_en;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_ex_freeze;
  logic             id_ex_flush;
  logic             ex_mem_freeze;
  logic             mem_stall;
  logic             mem_error;
  logic [15:0]      stall_cycles;

  modport master (
    output id_src1, id_src2, id_use_rn, id_two_src,
    output ex_dest, ex_wb_en, ex_mem_r_en,
    output mem_dest, mem_wb_en,
    output ex_branch_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, if_id_flush,
    input  id_ex_freeze, id_ex_flush, ex_mem_freeze,
    input  mem_stall, mem_error, stall_cycles
  );

  modport slave (
    input  id_src1, id_src2, id_use_rn, id_two_src,
    input  ex_dest, ex_wb_en, ex_mem_r_en,
    input  mem_dest, mem_wb_en,
    input  ex_branch_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, if_id_flush,
    output id_ex_freeze, id_ex_flush, ex_mem_freeze,
    output mem_stall, mem_error, stall_cycles
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Freeze/flush controller for IF/ID, ID/EX and EX/MEM: RAW hazards, taken branches, memory waits.
// Define FORWARDING_EN to restrict hazard detection to load-use (ALU results forwarded).
module hazard_flush_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned REG_W       = 4
) (
  input logic           clk,
  input logic           rst,
  hazard_flush_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MEM_ERR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_nx;

  logic        hit_ex;
  logic        hazard;
  logic        mem_hold;
  logic [15:0] stall_cnt;
  logic        err_q;

  logic pc_freeze;
  logic if_id_freeze;
  logic if_id_flush;
  logic id_ex_freeze;
  logic id_ex_flush;
  logic ex_mem_freeze;
  logic mem_stall;

  // RAW hazard detection on the ID instruction's source operands
  always_comb begin
    hit_ex = (bus.id_use_rn  & (bus.id_src1 == bus.ex_dest)) |
             (bus.id_two_src & (bus.id_src2 == bus.ex_dest));
`ifdef FORWARDING_EN
    hazard = bus.ex_wb_en & bus.ex_mem_r_en & hit_ex;
`else
    hazard = (bus.ex_wb_en & hit_ex) |
             (bus.mem_wb_en &
              ((bus.id_use_rn  & (bus.id_src1 == bus.mem_dest)) |
               (bus.id_two_src & (bus.id_src2 == bus.mem_dest))));
`endif
  end

  // Whole-pipeline hold: memory still busy, or the controller is latched in the error state
  always_comb begin
    mem_hold = 1'b0;
    unique case (state)
      RUN:      mem_hold = bus.mem_req & ~bus.mem_ready;
      MEM_WAIT: mem_hold = ~bus.mem_ready;
      MEM_ERR:  mem_hold = 1'b1;
      default:  mem_hold = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Next-state logic; wait_cnt counts wait cycles including the one that left RUN
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    unique case (state)
      RUN: begin
        if (bus.mem_req & ~bus.mem_ready) begin
          wait_cnt_nx = CW'(1);
          state_nx    = (MEM_TIMEOUT <= 1) ? MEM_ERR : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (~bus.mem_ready) begin
          wait_cnt_nx = wait_cnt + CW'(1);
          if (wait_cnt_nx >= CW'(MEM_TIMEOUT)) begin
            state_nx = MEM_ERR;
          end
        end else begin
          wait_cnt_nx = '0;
          state_nx    = RUN;
        end
      end
      MEM_ERR: begin
        state_nx = MEM_ERR;
      end
      default: begin
        state_nx    = RUN;
        wait_cnt_nx = '0;
      end
    endcase
  end

  // Mealy output decode; a branch or hazard seen during a wait acts in the release cycle
  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_freeze  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_freeze = 1'b0;
    mem_stall     = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        pc_freeze     = 1'b1;
        if_id_freeze  = 1'b1;
        id_ex_freeze  = 1'b1;
        ex_mem_freeze = 1'b1;
        mem_stall     = 1'b1;
      end else if (bus.ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Sticky timeout flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (state_nx == MEM_ERR) begin
        err_q <= 1'b1;
      end
      if (pc_freeze && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign bus.pc_freeze     = pc_freeze;
  assign bus.if_id_freeze  = if_id_freeze;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_freeze  = id_ex_freeze;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_freeze = ex_mem_freeze;
  assign bus.mem_stall     = mem_stall;
  assign bus.mem_error     = err_q;
  assign bus.stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: directed cases then randomized traffic vs a behavioural model.
module tb_hazard_flush_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned RW      = 4;

  typedef struct packed {
    logic          rst;
    logic [RW-1:0] id_src1;
    logic [RW-1:0] id_src2;
    logic          id_use_rn;
    logic          id_two_src;
    logic [RW-1:0] ex_dest;
    logic          ex_wb_en;
    logic          ex_mem_r_en;
    logic [RW-1:0] mem_dest;
    logic          mem_wb_en;
    logic          ex_branch_taken;
    logic          mem_req;
    logic          mem_ready;
  } stim_t;

  // {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze, mem_stall, mem_error, stall_cycles}
  typedef struct packed {
    logic [6:0]  ctl;
    logic        err;
    logic [15:0] stalls;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_flush_ctrl_if #(.REG_W(RW)) bus ();

  hazard_flush_ctrl #(.MEM_TIMEOUT(TIMEOUT), .REG_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  // Behavioural model state
  bit m_waiting = 0;
  bit m_errored = 0;
  int m_waited  = 0;
  int m_stalls  = 0;

  function automatic bit reads(stim_t s, logic [RW-1:0] x);
    return (s.id_use_rn && s.id_src1 == x) || (s.id_two_src && s.id_src2 == x);
  endfunction

  function automatic bit ref_hazard(stim_t s);
`ifdef FORWARDING_EN
    return s.ex_wb_en && s.ex_mem_r_en && reads(s, s.ex_dest);
`else
    return (s.ex_wb_en && reads(s, s.ex_dest)) || (s.mem_wb_en && reads(s, s.mem_dest));
`endif
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Apply one cycle of stimulus, predict outputs, advance the model across the next edge
  task automatic step(input stim_t s);
    out_t e;
    bit   memwait;
    bit   pcf;
    sb_t  item;
    @(posedge clk);
    #1;
    cyc                 = cyc + 1;
    rst                 = s.rst;
    bus.id_src1         = s.id_src1;
    bus.id_src2         = s.id_src2;
    bus.id_use_rn       = s.id_use_rn;
    bus.id_two_src      = s.id_two_src;
    bus.ex_dest         = s.ex_dest;
    bus.ex_wb_en        = s.ex_wb_en;
    bus.ex_mem_r_en     = s.ex_mem_r_en;
    bus.mem_dest        = s.mem_dest;
    bus.mem_wb_en       = s.mem_wb_en;
    bus.ex_branch_taken = s.ex_branch_taken;
    bus.mem_req         = s.mem_req;
    bus.mem_ready       = s.mem_ready;

    memwait = !m_errored && !s.mem_ready && (m_waiting || s.mem_req);
    e.ctl   = 7'b0;
    if (!s.rst) begin
      if (m_errored || memwait)        e.ctl = 7'b1101011;
      else if (s.ex_branch_taken)      e.ctl = 7'b0010100;
      else if (ref_hazard(s))          e.ctl = 7'b1100100;
    end
    e.err    = m_errored;
    e.stalls = 16'(m_stalls);
    item.cyc = cyc;
    item.exp = e;
    sb_q.push_back(item);

    pcf = e.ctl[6];
    if (s.rst) begin
      m_waiting = 0; m_errored = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (pcf && m_stalls < 65535) m_stalls = m_stalls + 1;
      if (m_errored) begin
        m_waiting = 0;
      end else if (memwait) begin
        m_waited = m_waited + 1;
        if (m_waited >= int'(TIMEOUT)) begin
          m_errored = 1; m_waiting = 0;
        end else begin
          m_waiting = 1;
        end
      end else begin
        m_waiting = 0; m_waited = 0;
      end
    end
  endtask

  // Monitor: compares the DUT outputs once per cycle against the queued prediction
  initial begin
    sb_t  it;
    out_t act;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        it  = sb_q.pop_front();
        act = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_freeze,
               bus.id_ex_flush, bus.ex_mem_freeze, bus.mem_stall, bus.mem_error, bus.stall_cycles};
        checks = checks + 1;
        if (act !== it.exp) begin
          failures = failures + 1;
          $display("FAIL outputs cycle=%0d actual=%h expected=%h", it.cyc, act, it.exp);
        end
      end
    end
  end

  initial begin
    stim_t s;
    bus.id_src1 = '0; bus.id_src2 = '0; bus.id_use_rn = 0; bus.id_two_src = 0;
    bus.ex_dest = '0; bus.ex_wb_en = 0; bus.ex_mem_r_en = 0; bus.mem_dest = '0;
    bus.mem_wb_en = 0; bus.ex_branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;

    s = idle(); s.rst = 1; step(s); step(s);
    s = idle(); step(s);

    // Load-use, then producer changes
    s = idle(); s.ex_mem_r_en = 1; s.ex_wb_en = 1; s.ex_dest = 3; s.id_src1 = 3; s.id_use_rn = 1;
    step(s);
    s.ex_dest = 0; step(s);

    // ALU dependence on the second source
    s = idle(); s.ex_wb_en = 1; s.ex_dest = 5; s.id_src2 = 5; s.id_two_src = 1;
    step(s); step(s);
    s = idle(); s.mem_wb_en = 1; s.mem_dest = 7; s.id_src1 = 7; s.id_use_rn = 1; step(s);

    // Branch together with load-use
    s = idle(); s.ex_mem_r_en = 1; s.ex_wb_en = 1; s.ex_dest = 3; s.id_src1 = 3; s.id_use_rn = 1;
    s.ex_branch_taken = 1; step(s);

    // Memory wait of three cycles
    s = idle(); s.mem_req = 1; step(s); step(s); step(s);
    s.mem_ready = 1; step(s);
    s = idle(); step(s);

    // Branch held during a wait
    s = idle(); s.mem_req = 1; s.ex_branch_taken = 1; step(s); step(s);
    s.mem_ready = 1; step(s);
    s = idle(); step(s);

    // Wait released exactly one cycle before the timeout
    s = idle(); s.mem_req = 1;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) step(s);
    s.mem_ready = 1; step(s);

    // Timeout into the error state, then reset
    s = idle(); s.mem_req = 1;
    for (int i = 0; i < int'(TIMEOUT) + 4; i++) step(s);
    s.mem_ready = 1; step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s); step(s);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s                 = idle();
      s.rst             = ($urandom_range(0, 299) == 0);
      s.id_src1         = RW'($urandom_range(0, 3));
      s.id_src2         = RW'($urandom_range(0, 3));
      s.id_use_rn       = 1'($urandom_range(0, 1));
      s.id_two_src      = 1'($urandom_range(0, 1));
      s.ex_dest         = RW'($urandom_range(0, 3));
      s.ex_wb_en        = 1'($urandom_range(0, 1));
      s.ex_mem_r_en     = 1'($urandom_range(0, 1));
      s.mem_dest        = RW'($urandom_range(0, 3));
      s.mem_wb_en       = 1'($urandom_range(0, 1));
      s.ex_branch_taken = ($urandom_range(0, 5) == 0);
      s.mem_req         = ($urandom_range(0, 4) == 0);
      s.mem_ready       = ($urandom_range(0, 99) < 55);
      step(s);
    end

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
